// File: rtl/elbeth_lsu_if.sv
// ---------------------------------------------------------------------------
// elbeth_lsu_if
//   Bundles the core-side data-request signals and the memory-side port
//   signals of the elbeth load/store unit.
//
//   Parameter
//     ADDR_WIDTH    memory word-address width
//
//   Core side
//     dmem_req, dmem_we, dmem_addr[31:0], dmem_wdata[31:0], dmem_size[1:0],
//     dmem_unsigned                       core -> LSU
//     dmem_rdata[31:0], dmem_ready, dmem_err, dmem_busy
//                                         LSU  -> core
//   Memory side
//     mem_enable, mem_addr[ADDR_WIDTH-1:0], mem_data_in[31:0], mem_wr[3:0]
//                                         LSU  -> memory
//     mem_data_out[31:0], mem_ready       memory -> LSU
//
//   Modports
//     slave   the LSU itself
//     master  the environment around it (core plus memory)
// ---------------------------------------------------------------------------
interface elbeth_lsu_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  // core request side
  logic                  dmem_req;
  logic                  dmem_we;
  logic [31:0]           dmem_addr;
  logic [31:0]           dmem_wdata;
  logic [1:0]            dmem_size;
  logic                  dmem_unsigned;
  logic [31:0]           dmem_rdata;
  logic                  dmem_ready;
  logic                  dmem_err;
  logic                  dmem_busy;

  // memory port side
  logic                  mem_enable;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_data_in;
  logic [3:0]            mem_wr;
  logic [31:0]           mem_data_out;
  logic                  mem_ready;

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_size, dmem_unsigned,
    output dmem_rdata, dmem_ready, dmem_err, dmem_busy,
    output mem_enable, mem_addr, mem_data_in, mem_wr,
    input  mem_data_out, mem_ready
  );

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_size, dmem_unsigned,
    input  dmem_rdata, dmem_ready, dmem_err, dmem_busy,
    input  mem_enable, mem_addr, mem_data_in, mem_wr,
    output mem_data_out, mem_ready
  );
endinterface

// File: rtl/elbeth_lsu.sv
// ---------------------------------------------------------------------------
// elbeth_lsu
//   Load/store unit between the core's data-request interface and one port
//   of elbeth_memory. Byte/half/word accesses become word-addressed memory
//   transactions with a 4-bit byte-write mask. The transaction is held on the
//   memory port until mem_ready, then load data is aligned and sign/zero
//   extended and returned with a one-cycle dmem_ready pulse. A watchdog
//   aborts transactions the memory never completes (dmem_err=1).
//
//   Parameters
//     ADDR_WIDTH      memory word-address width; mem_addr = dmem_addr[ADDR_WIDTH+1:2]
//     TIMEOUT_CYCLES  max ACCESS cycles waiting for mem_ready; 0 disables the watchdog
//
//   Ports
//     clk   in  rising-edge clock
//     rst   in  asynchronous, active-high reset
//     bus   elbeth_lsu_if.slave  (core request side + memory port side)
//
//   Optional feature (compile-time macro)
//     ELBETH_LSU_MISALIGN_EXC_EN
//       defined:   misaligned half/word requests skip the memory and complete
//                  the following cycle with dmem_err=1, dmem_rdata=0
//       undefined: offending low address bits are forced to zero
//
//   Timing: req sampled in cycle 0, mem_enable from cycle 1, mem_ready in
//   cycle k gives dmem_ready in cycle k+1. All outputs are registered.
// ---------------------------------------------------------------------------
module elbeth_lsu #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  elbeth_lsu_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  // Watchdog counter only has to reach TIMEOUT_CYCLES-1.
  localparam int unsigned WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned WD_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LAST_I);

  state_t          state;
  logic            req_we;
  logic [1:0]      req_size;
  logic [1:0]      req_off;
  logic            req_unsigned;
  logic [WD_W-1:0] wd_cnt;

  // Decoded view of the incoming request.
  logic [1:0]  in_off;
  logic [3:0]  in_mask;
  logic [31:0] in_lanes;

  // Address bits above the memory window alias; they are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.dmem_addr[31:ADDR_WIDTH+2];

  // Half accesses use the half-aligned offset and words always use offset 0,
  // so the misaligned low bits are dropped here for every request.
  always_comb begin
    in_off   = 2'b00;
    in_mask  = 4'b1111;
    in_lanes = bus.dmem_wdata;
    case (bus.dmem_size)
      2'b00: begin
        in_off   = bus.dmem_addr[1:0];
        in_mask  = 4'b0001 << bus.dmem_addr[1:0];
        in_lanes = {4{bus.dmem_wdata[7:0]}};
      end
      2'b01: begin
        in_off   = {bus.dmem_addr[1], 1'b0};
        in_mask  = 4'b0011 << {bus.dmem_addr[1], 1'b0};
        in_lanes = {2{bus.dmem_wdata[15:0]}};
      end
      default: begin
        in_off   = 2'b00;
        in_mask  = 4'b1111;
        in_lanes = bus.dmem_wdata;
      end
    endcase
  end

`ifdef ELBETH_LSU_MISALIGN_EXC_EN
  logic in_misaligned;
  assign in_misaligned = (bus.dmem_size == 2'b01) ? bus.dmem_addr[0]
                       : (bus.dmem_size[1] && (bus.dmem_addr[1:0] != 2'b00));
`endif

  // Select the addressed byte/half of the memory word and extend it.
  function automatic logic [31:0] load_extract(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  off,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   load_extract = {{24{b[7] & ~uns}}, b};
      2'b01:   load_extract = {{16{h[15] & ~uns}}, h};
      default: load_extract = word;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      req_we          <= 1'b0;
      req_size        <= 2'b00;
      req_off         <= 2'b00;
      req_unsigned    <= 1'b0;
      wd_cnt          <= '0;
      bus.dmem_rdata  <= '0;
      bus.dmem_ready  <= 1'b0;
      bus.dmem_err    <= 1'b0;
      bus.dmem_busy   <= 1'b0;
      bus.mem_enable  <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_data_in <= '0;
      bus.mem_wr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.dmem_req) begin
            req_we          <= bus.dmem_we;
            req_size        <= bus.dmem_size;
            req_off         <= in_off;
            req_unsigned    <= bus.dmem_unsigned;
            wd_cnt          <= '0;
            bus.dmem_busy   <= 1'b1;
            bus.mem_addr    <= bus.dmem_addr[ADDR_WIDTH+1:2];
            bus.mem_data_in <= in_lanes;
            bus.mem_wr      <= bus.dmem_we ? in_mask : 4'b0000;
`ifdef ELBETH_LSU_MISALIGN_EXC_EN
            if (in_misaligned) begin
              // Memory port stays disabled; answer with an error next cycle.
              state          <= RESPOND;
              bus.dmem_ready <= 1'b1;
              bus.dmem_err   <= 1'b1;
              bus.dmem_rdata <= '0;
            end else begin
              state          <= ACCESS;
              bus.mem_enable <= 1'b1;
            end
`else
            state          <= ACCESS;
            bus.mem_enable <= 1'b1;
`endif
          end
        end

        ACCESS: begin
          // mem_ready takes priority over a watchdog expiry in the same cycle.
          if (bus.mem_ready) begin
            state          <= RESPOND;
            bus.mem_enable <= 1'b0;
            bus.dmem_ready <= 1'b1;
            bus.dmem_err   <= 1'b0;
            bus.dmem_rdata <= req_we ? '0
                            : load_extract(bus.mem_data_out, req_size, req_off, req_unsigned);
          end else if ((TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST)) begin
            state          <= RESPOND;
            bus.mem_enable <= 1'b0;
            bus.dmem_ready <= 1'b1;
            bus.dmem_err   <= 1'b1;
            bus.dmem_rdata <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        RESPOND: begin
          state          <= IDLE;
          bus.dmem_ready <= 1'b0;
          bus.dmem_err   <= 1'b0;
          bus.dmem_rdata <= '0;
          bus.dmem_busy  <= 1'b0;
        end

        default: begin
          state          <= IDLE;
          bus.mem_enable <= 1'b0;
          bus.dmem_ready <= 1'b0;
          bus.dmem_err   <= 1'b0;
          bus.dmem_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elbeth_lsu.sv
// ---------------------------------------------------------------------------
// tb_elbeth_lsu
//   Directed bench for elbeth_lsu. Main instance uses TIMEOUT_CYCLES=16, a
//   second instance uses TIMEOUT_CYCLES=4 for the short-watchdog cases.
//   Each instance has a memory model whose mem_ready fires after a
//   programmable number of enabled cycles (delay 0 = ready in the first
//   enabled cycle), or never when hang is set.
// ---------------------------------------------------------------------------
module tb_elbeth_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  elbeth_lsu_if #(.ADDR_WIDTH(8)) bus ();
  elbeth_lsu_if #(.ADDR_WIDTH(8)) bus_to ();

  elbeth_lsu #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  elbeth_lsu #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(4)) dut_to (
    .clk (clk),
    .rst (rst),
    .bus (bus_to)
  );

  // ---------------- memory models ----------------
  int          mem_delay = 0;
  int          to_delay  = 0;
  logic        mem_hang  = 1'b0;
  logic        to_hang   = 1'b0;
  logic [31:0] mem_word  = '0;
  logic [31:0] to_word   = '0;
  int          en_cnt    = 0;
  int          to_cnt    = 0;

  always @(posedge clk) begin
    en_cnt <= bus.mem_enable    ? en_cnt + 1 : 0;
    to_cnt <= bus_to.mem_enable ? to_cnt + 1 : 0;
  end

  assign bus.mem_ready       = bus.mem_enable && !mem_hang && (en_cnt == mem_delay);
  assign bus.mem_data_out    = mem_word;
  assign bus_to.mem_ready    = bus_to.mem_enable && !to_hang && (to_cnt == to_delay);
  assign bus_to.mem_data_out = to_word;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    int          rdy;     // cycle of dmem_ready (req sampled in cycle 0), -1 if never
    logic [31:0] rdata;
    logic        err;
    int          en;      // number of cycles mem_enable was high
    logic [7:0]  maddr;
    logic [3:0]  mwr;
    logic [31:0] mdin;
    logic        stable;  // addr/mask/data unchanged while enabled
    logic        busy1;   // dmem_busy in cycle 1
  } res_t;

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, output res_t r);
    @(posedge clk); #1;
    bus.dmem_we       = we;
    bus.dmem_addr     = addr;
    bus.dmem_wdata    = wdata;
    bus.dmem_size     = size;
    bus.dmem_unsigned = uns;
    bus.dmem_req      = 1'b1;
    @(posedge clk); #1;
    bus.dmem_req = 1'b0;
    r = '{rdy: -1, rdata: '0, err: 1'b0, en: 0, maddr: '0, mwr: '0, mdin: '0,
          stable: 1'b1, busy1: 1'b0};
    for (int c = 1; c <= 40 && r.rdy < 0; c++) begin
      @(negedge clk);
      if (c == 1) r.busy1 = bus.dmem_busy;
      if (bus.mem_enable) begin
        if (r.en == 0) begin
          r.maddr = bus.mem_addr;
          r.mwr   = bus.mem_wr;
          r.mdin  = bus.mem_data_in;
        end else if (bus.mem_addr != r.maddr || bus.mem_wr != r.mwr || bus.mem_data_in != r.mdin) begin
          r.stable = 1'b0;
        end
        r.en++;
      end
      if (bus.dmem_ready) begin
        r.rdy   = c;
        r.rdata = bus.dmem_rdata;
        r.err   = bus.dmem_err;
      end
    end
  endtask

  // Word load at 0x8 on the short-watchdog instance.
  task automatic run_to(output res_t r);
    @(posedge clk); #1;
    bus_to.dmem_we       = 1'b0;
    bus_to.dmem_addr     = 32'h8;
    bus_to.dmem_wdata    = '0;
    bus_to.dmem_size     = 2'b10;
    bus_to.dmem_unsigned = 1'b0;
    bus_to.dmem_req      = 1'b1;
    @(posedge clk); #1;
    bus_to.dmem_req = 1'b0;
    r = '{rdy: -1, rdata: '0, err: 1'b0, en: 0, maddr: '0, mwr: '0, mdin: '0,
          stable: 1'b1, busy1: 1'b0};
    for (int c = 1; c <= 40 && r.rdy < 0; c++) begin
      @(negedge clk);
      if (bus_to.mem_enable) r.en++;
      if (bus_to.dmem_ready) begin
        r.rdy   = c;
        r.rdata = bus_to.dmem_rdata;
        r.err   = bus_to.dmem_err;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    int          dly;
    logic [31:0] mword;
    logic [7:0]  e_maddr;
    logic [3:0]  e_mwr;
    logic [31:0] e_mdin;   // checked for stores only
    logic [31:0] e_rdata;
    int          e_rdy;
  } vec_t;

  vec_t vt[12];

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    res_t r;
    logic seen;

    bus.dmem_req = 1'b0;      bus.dmem_we = 1'b0;     bus.dmem_addr = '0;
    bus.dmem_wdata = '0;      bus.dmem_size = 2'b00;  bus.dmem_unsigned = 1'b0;
    bus_to.dmem_req = 1'b0;   bus_to.dmem_we = 1'b0;  bus_to.dmem_addr = '0;
    bus_to.dmem_wdata = '0;   bus_to.dmem_size = 2'b00; bus_to.dmem_unsigned = 1'b0;

    //          we  addr        wdata         size   uns dly mword         maddr  mwr      mdin          rdata         rdy
    vt[0]  = '{1'b1, 32'h5,     32'h000000AB, 2'b00, 1'b0, 0, 32'h0,        8'h01, 4'b0010, 32'hABABABAB, 32'h0,        2};
    vt[1]  = '{1'b0, 32'h6,     32'h0,        2'b01, 1'b0, 1, 32'h80010000, 8'h01, 4'b0000, 32'h0,        32'hFFFF8001, 3};
    vt[2]  = '{1'b0, 32'h6,     32'h0,        2'b01, 1'b1, 2, 32'h80010000, 8'h01, 4'b0000, 32'h0,        32'h00008001, 4};
    vt[3]  = '{1'b0, 32'h8,     32'h0,        2'b10, 1'b0, 5, 32'hDEADBEEF, 8'h02, 4'b0000, 32'h0,        32'hDEADBEEF, 7};
    vt[4]  = '{1'b1, 32'h2,     32'h12345678, 2'b01, 1'b0, 0, 32'h0,        8'h00, 4'b1100, 32'h56785678, 32'h0,        2};
    vt[5]  = '{1'b1, 32'hC,     32'hCAFEF00D, 2'b10, 1'b0, 3, 32'h0,        8'h03, 4'b1111, 32'hCAFEF00D, 32'h0,        5};
    vt[6]  = '{1'b0, 32'h7,     32'h0,        2'b00, 1'b0, 0, 32'h9A000000, 8'h01, 4'b0000, 32'h0,        32'hFFFFFF9A, 2};
    vt[7]  = '{1'b0, 32'h1,     32'h0,        2'b00, 1'b1, 0, 32'h0000F100, 8'h00, 4'b0000, 32'h0,        32'h000000F1, 2};
    vt[8]  = '{1'b0, 32'h7F6,   32'h0,        2'b00, 1'b0, 4, 32'h007F0000, 8'hFD, 4'b0000, 32'h0,        32'h0000007F, 6};
    vt[9]  = '{1'b0, 32'h10,    32'h0,        2'b11, 1'b0, 1, 32'h01234567, 8'h04, 4'b0000, 32'h0,        32'h01234567, 3};
    vt[10] = '{1'b1, 32'h3,     32'hFFFFFF5A, 2'b00, 1'b0, 2, 32'hFFFFFFFF, 8'h00, 4'b1000, 32'h5A5A5A5A, 32'h0,        4};
    vt[11] = '{1'b0, 32'h20,    32'h0,        2'b01, 1'b0, 0, 32'hFFFF7FFE, 8'h08, 4'b0000, 32'h0,        32'h00007FFE, 2};

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dmem_rdata", bus.dmem_rdata, 32'h0);
    check("rst_dmem_ready", 32'(bus.dmem_ready), 32'h0);
    check("rst_dmem_err",   32'(bus.dmem_err), 32'h0);
    check("rst_dmem_busy",  32'(bus.dmem_busy), 32'h0);
    check("rst_mem_enable", 32'(bus.mem_enable), 32'h0);
    check("rst_mem_addr",   32'(bus.mem_addr), 32'h0);
    check("rst_mem_wr",     32'(bus.mem_wr), 32'h0);
    check("rst_mem_data_in", bus.mem_data_in, 32'h0);
    check("rst_to_enable",  32'(bus_to.mem_enable), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ---- table-driven transactions ----
    for (int i = 0; i < 12; i++) begin
      mem_delay = vt[i].dly;
      mem_word  = vt[i].mword;
      run_txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].size, vt[i].uns, r);
      check($sformatf("v%0d_ready_cycle", i), 32'(r.rdy), 32'(vt[i].e_rdy));
      check($sformatf("v%0d_err", i),         32'(r.err), 32'h0);
      check($sformatf("v%0d_rdata", i),       r.rdata, vt[i].e_rdata);
      check($sformatf("v%0d_mem_addr", i),    32'(r.maddr), 32'(vt[i].e_maddr));
      check($sformatf("v%0d_mem_wr", i),      32'(r.mwr), 32'(vt[i].e_mwr));
      check($sformatf("v%0d_enable_cycles", i), 32'(r.en), 32'(vt[i].dly + 1));
      check($sformatf("v%0d_stable", i),      32'(r.stable), 32'h1);
      check($sformatf("v%0d_busy", i),        32'(r.busy1), 32'h1);
      if (vt[i].we)
        check($sformatf("v%0d_mem_data_in", i), r.mdin, vt[i].e_mdin);
    end

    // ---- misaligned word load at 0x3 and half store at 0x5 ----
    mem_delay = 0;
    mem_word  = 32'hA1B2C3D4;
    run_txn(1'b0, 32'h3, 32'h0, 2'b10, 1'b0, r);
`ifdef ELBETH_LSU_MISALIGN_EXC_EN
    check("mis_w_ready_cycle", 32'(r.rdy), 32'd1);
    check("mis_w_err",         32'(r.err), 32'h1);
    check("mis_w_rdata",       r.rdata, 32'h0);
    check("mis_w_enable",      32'(r.en), 32'd0);
`else
    check("mis_w_ready_cycle", 32'(r.rdy), 32'd2);
    check("mis_w_err",         32'(r.err), 32'h0);
    check("mis_w_rdata",       r.rdata, 32'hA1B2C3D4);
    check("mis_w_mem_addr",    32'(r.maddr), 32'h0);
    check("mis_w_mem_wr",      32'(r.mwr), 32'h0);
`endif
    run_txn(1'b1, 32'h5, 32'h0000BEEF, 2'b01, 1'b0, r);
`ifdef ELBETH_LSU_MISALIGN_EXC_EN
    check("mis_h_ready_cycle", 32'(r.rdy), 32'd1);
    check("mis_h_err",         32'(r.err), 32'h1);
    check("mis_h_enable",      32'(r.en), 32'd0);
`else
    check("mis_h_ready_cycle", 32'(r.rdy), 32'd2);
    check("mis_h_err",         32'(r.err), 32'h0);
    check("mis_h_mem_addr",    32'(r.maddr), 32'h1);
    check("mis_h_mem_wr",      32'(r.mwr), 32'b0011);
    check("mis_h_mem_data_in", r.mdin, 32'hBEEFBEEF);
`endif

    // ---- watchdog, TIMEOUT_CYCLES=4: never ready ----
    to_hang = 1'b1;
    to_word = 32'h55AA33CC;
    run_to(r);
    check("to4_ready_cycle", 32'(r.rdy), 32'd5);
    check("to4_err",         32'(r.err), 32'h1);
    check("to4_rdata",       r.rdata, 32'h0);
    check("to4_enable",      32'(r.en), 32'd4);

    // mem_ready in the last watchdog cycle completes normally
    to_hang  = 1'b0;
    to_delay = 3;
    run_to(r);
    check("to4_race_ready_cycle", 32'(r.rdy), 32'd5);
    check("to4_race_err",         32'(r.err), 32'h0);
    check("to4_race_rdata",       r.rdata, 32'h55AA33CC);

    // ---- watchdog, TIMEOUT_CYCLES=16: never ready ----
    mem_hang = 1'b1;
    mem_word = 32'h13579BDF;
    run_txn(1'b0, 32'h8, 32'h0, 2'b10, 1'b0, r);
    check("to16_ready_cycle", 32'(r.rdy), 32'd17);
    check("to16_err",         32'(r.err), 32'h1);
    check("to16_rdata",       r.rdata, 32'h0);
    check("to16_enable",      32'(r.en), 32'd16);
    mem_hang = 1'b0;

    // ---- reset in the middle of ACCESS ----
    mem_delay = 10;
    mem_word  = 32'h0BADF00D;
    @(posedge clk); #1;
    bus.dmem_we = 1'b0; bus.dmem_addr = 32'h14; bus.dmem_size = 2'b10;
    bus.dmem_unsigned = 1'b0; bus.dmem_req = 1'b1;
    @(posedge clk); #1;
    bus.dmem_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_pre_enable", 32'(bus.mem_enable), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_enable", 32'(bus.mem_enable), 32'h0);
    check("rst_mid_busy",   32'(bus.dmem_busy), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.dmem_ready || bus.mem_enable) seen = 1'b1;
    end
    check("rst_mid_no_ready", 32'(seen), 32'h0);

    mem_delay = 0;
    run_txn(1'b0, 32'h14, 32'h0, 2'b10, 1'b0, r);
    check("post_rst_ready_cycle", 32'(r.rdy), 32'd2);
    check("post_rst_err",         32'(r.err), 32'h0);
    check("post_rst_rdata",       r.rdata, 32'h0BADF00D);
    check("post_rst_mem_addr",    32'(r.maddr), 32'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
